// File: rtl/rom_pkg.sv
// ---------------------------------------------------------------------------
// rom_pkg
// Shared definitions for the ROM download path.
//   ROM_AW         : default memory address width (image of 2**ROM_AW bytes)
//   loaderState_e  : loader FSM state encoding
// ---------------------------------------------------------------------------
package rom_pkg;

    localparam int ROM_AW = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } loaderState_e;

endpackage

// File: rtl/rom_loader_if.sv
// ---------------------------------------------------------------------------
// rom_loader_if
// Bundles the download byte stream and the memory write port seen by the
// ROM loader.
//   dl_active : frame level from the download source
//   dl_valid  : dl_data holds a byte
//   dl_data   : download byte
//   dl_ready  : loader accepts the byte when dl_valid && dl_ready
//   we/wa/wd  : memory write strobe, address and data
// Modports:
//   slave  : the loader (consumes the stream, drives the memory port)
//   master : the surrounding system (download source + memory)
// ---------------------------------------------------------------------------
interface rom_loader_if
    import rom_pkg::*;
#(
    parameter int AW = ROM_AW
);

    logic          dl_active;
    logic          dl_valid;
    logic [7:0]    dl_data;
    logic          dl_ready;
    logic          we;
    logic [AW-1:0] wa;
    logic [7:0]    wd;

    modport slave (
        input  dl_active, dl_valid, dl_data,
        output dl_ready, we, wa, wd
    );

    modport master (
        output dl_active, dl_valid, dl_data,
        input  dl_ready, we, wa, wd
    );

endinterface

// File: rtl/dl_edge.sv
// ---------------------------------------------------------------------------
// dl_edge
// One-flop edge detector for a download frame level.
//   clock   : system clock
//   reset   : synchronous active-high reset
//   level_i : frame level
//   rise_o  : level went high (registered low, current high)
//   fall_o  : level went low  (registered high, current low)
// ---------------------------------------------------------------------------
module dl_edge (
    input  logic clock,
    input  logic reset,
    input  logic level_i,
    output logic rise_o,
    output logic fall_o
);

    logic level_q;

    // Remember last cycle's level so the edges can be formed combinationally
    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;
    assign fall_o = level_q & ~level_i;

endmodule

// File: rtl/rom_loader.sv
// ---------------------------------------------------------------------------
// rom_loader
// Writes a framed download byte stream sequentially into the ROM/RAM write
// port starting at address 0, paced by the memory clock-enable.
//   clock    : system clock
//   reset    : synchronous active-high reset
//   ce       : memory clock-enable; writes only issue when ce=1
//   bus      : download stream in, memory write port out (slave side)
//   busy     : load in progress (LOAD or FLUSH)
//   done     : one-cycle pulse when a frame completes
//   size     : bytes written in the last/current frame
//   sum      : modulo-256 sum of the bytes written
//   overflow : frame carried more than 2**AW bytes (sticky until next start)
// ---------------------------------------------------------------------------
module rom_loader
    import rom_pkg::*;
#(
    parameter int AW = ROM_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    rom_loader_if.slave   bus,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   size,
    output logic [7:0]    sum,
    output logic          overflow
);

    localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

    loaderState_e  state_q, state_d;
    logic          pending_q, pending_d;
    logic [7:0]    wd_q, wd_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [AW:0]   size_q, size_d;
    logic [7:0]    sum_q, sum_d;
    logic          ovf_q, ovf_d;
    logic          startHeld_q, startHeld_d;

    logic startRise;
    logic endFall;
    logic readyInt;
    logic accept;
    logic writeFire;
    logic isFull;

    dl_edge uEdge (
        .clock   (clock),
        .reset   (reset),
        .level_i (bus.dl_active),
        .rise_o  (startRise),
        .fall_o  (endFall)
    );

    assign readyInt  = (state_q == LOAD) && !pending_q;
    assign accept    = bus.dl_valid && readyInt;
    assign isFull    = (size_q == FULL_COUNT);
    // The slot drains in FLUSH too, so a byte taken together with the end
    // of frame still reaches memory.
    assign writeFire = pending_q && ce && ((state_q == LOAD) || (state_q == FLUSH));

    // Next-state logic for the FSM, the single-byte write slot and the
    // frame counters. The write commit is applied after the state case so
    // it works the same way in LOAD and FLUSH.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        wd_d        = wd_q;
        wa_d        = wa_q;
        size_d      = size_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        startHeld_d = startHeld_q;

        unique case (state_q)
            IDLE: begin
                if (startRise || startHeld_q) begin
                    state_d     = LOAD;
                    wa_d        = '0;
                    size_d      = '0;
                    sum_d       = '0;
                    ovf_d       = 1'b0;
                    startHeld_d = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    // Bytes beyond capacity are swallowed, only flagged
                    if (isFull) begin
                        ovf_d = 1'b1;
                    end else begin
                        wd_d      = bus.dl_data;
                        pending_d = 1'b1;
                    end
                end
                if (endFall) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!pending_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                // A new frame starting right now must not be lost; IDLE
                // picks it up from the held flag.
                if (startRise) begin
                    startHeld_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (writeFire) begin
            wa_d      = wa_q + AW'(1);
            size_d    = size_q + (AW + 1)'(1);
            sum_d     = sum_q + wd_q;
            pending_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            wd_q        <= '0;
            wa_q        <= '0;
            size_q      <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            startHeld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            wd_q        <= wd_d;
            wa_q        <= wa_d;
            size_q      <= size_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            startHeld_q <= startHeld_d;
        end
    end

    // The strobe is gated by reset so an abandoned frame stops writing in
    // the very cycle reset is raised.
    assign bus.we       = writeFire && !reset;
    assign bus.wa       = wa_q;
    assign bus.wd       = wd_q;
    assign bus.dl_ready = readyInt;

    assign busy     = (state_q == LOAD) || (state_q == FLUSH);
    assign done     = (state_q == DONE);
    assign size     = size_q;
    assign sum      = sum_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_rom_loader
// Bench for rom_loader with a 4-byte image so the capacity limit is reachable.
// Expected memory writes are queued when a byte is offered and checked when
// the write strobe appears.
// ---------------------------------------------------------------------------
module tb_rom_loader;
    import rom_pkg::*;

    localparam int TB_AW = 2;
    localparam int CAP   = 1 << TB_AW;

    logic             clock = 1'b0;
    logic             reset;
    logic             ce;
    logic             busy;
    logic             done;
    logic [TB_AW:0]   size;
    logic [7:0]       sum;
    logic             overflow;

    int checks  = 0;
    int errors  = 0;
    int weCount = 0;
    int ceMode  = 0;
    int cyc     = 0;

    logic [TB_AW+7:0] expQ[$];
    logic [TB_AW+7:0] expEntry;
    int               expSize;
    logic [7:0]       expSum;
    logic             expOvf;
    logic [TB_AW-1:0] expAddr;

    rom_loader_if #(.AW(TB_AW)) bus ();

    rom_loader #(.AW(TB_AW)) dut (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .size     (size),
        .sum      (sum),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    // Clock-enable pattern: always high, or high one cycle in four
    initial begin
        ce = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            ce = (ceMode == 0) ? 1'b1 : ((cyc % 4) == 0);
        end
    end

    // Write monitor: every strobe must match the oldest expected write
    always @(negedge clock) begin
        if (bus.we === 1'b1) begin
            weCount++;
            checks++;
            if (ce !== 1'b1) begin
                errors++;
                $display("[TB] FAIL we_without_ce got ce=%b want 1", ce);
            end
            checks++;
            if (bus.dl_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ready_while_pending got %b want 0", bus.dl_ready);
            end
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_we got wa=%h wd=%h want no write", bus.wa, bus.wd);
            end else begin
                expEntry = expQ.pop_front();
                if ({bus.wa, bus.wd} !== expEntry) begin
                    errors++;
                    $display("[TB] FAIL write got wa=%h wd=%h want wa=%h wd=%h",
                             bus.wa, bus.wd, expEntry[TB_AW+7:8], expEntry[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Raise the frame and clear the reference model
    task automatic startFrame();
        expSize = 0;
        expSum  = 8'h00;
        expOvf  = 1'b0;
        expAddr = '0;
        weCount = 0;
        bus.dl_active = 1'b1;
        tick();
    endtask

    // Offer one byte; optionally end the frame in the accept cycle, and
    // optionally leave it out of the model (for the abandoned-frame case)
    task automatic sendByte(input logic [7:0] b, input bit endSame, input bit track);
        int waitCnt = 0;
        bus.dl_valid = 1'b1;
        bus.dl_data  = b;
        while (bus.dl_ready !== 1'b1 && waitCnt < 40) begin
            tick();
            waitCnt++;
        end
        if (bus.dl_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout got dl_ready=%b want 1", bus.dl_ready);
            bus.dl_valid = 1'b0;
            return;
        end
        if (track) begin
            if (expSize < CAP) begin
                expQ.push_back({expAddr, b});
                expAddr++;
                expSize++;
                expSum += b;
            end else begin
                expOvf = 1'b1;
            end
        end
        if (endSame) bus.dl_active = 1'b0;
        tick();
        bus.dl_valid = 1'b0;
    endtask

    // Drop the frame, watch a fixed window for done, then check results
    task automatic endAndWait(input string tag);
        int doneCnt = 0;
        bus.dl_active = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                doneCnt++;
                checks++;
                if (expQ.size() != 0) begin
                    errors++;
                    $display("[TB] FAIL %s done_before_write got %0d queued want 0", tag, expQ.size());
                end
            end
        end
        checks++;
        if (doneCnt != 1) begin
            errors++;
            $display("[TB] FAIL %s done_pulses got %0d want 1", tag, doneCnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s busy_after_done got %b want 0", tag, busy);
        end
        checks++;
        if (size !== expSize[TB_AW:0]) begin
            errors++;
            $display("[TB] FAIL %s size got %0d want %0d", tag, size, expSize);
        end
        checks++;
        if (sum !== expSum) begin
            errors++;
            $display("[TB] FAIL %s sum got %h want %h", tag, sum, expSum);
        end
        checks++;
        if (overflow !== expOvf) begin
            errors++;
            $display("[TB] FAIL %s overflow got %b want %b", tag, overflow, expOvf);
        end
        checks++;
        if (weCount != expSize) begin
            errors++;
            $display("[TB] FAIL %s we_count got %0d want %0d", tag, weCount, expSize);
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s missing_writes got %0d left want 0", tag, expQ.size());
        end
        tick();
    endtask

    // Everything quiet and zero
    task automatic checkIdleZero(input string tag);
        checks++;
        if ({bus.we, bus.wa, bus.wd, bus.dl_ready, busy, done, size, sum, overflow} !== '0) begin
            errors++;
            $display("[TB] FAIL %s outputs got we=%b wa=%h wd=%h rdy=%b busy=%b done=%b size=%0d sum=%h ovf=%b want all 0",
                     tag, bus.we, bus.wa, bus.wd, bus.dl_ready, busy, done, size, sum, overflow);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.dl_active = 1'b0;
        bus.dl_valid  = 1'b0;
        bus.dl_data   = 8'h00;
        repeat (3) tick();
        checkIdleZero("reset");
        reset = 1'b0;
        repeat (2) tick();
        checkIdleZero("post_reset");
    endtask

    task automatic test_basic();
        ceMode = 0;
        startFrame();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic busy_in_load got %b want 1", busy);
        end
        sendByte(8'h11, 1'b0, 1'b1);
        sendByte(8'h22, 1'b0, 1'b1);
        sendByte(8'h33, 1'b0, 1'b1);
        endAndWait("basic");
    endtask

    task automatic test_sparse_ce();
        ceMode = 1;
        startFrame();
        sendByte(8'h11, 1'b0, 1'b1);
        sendByte(8'h22, 1'b0, 1'b1);
        sendByte(8'h33, 1'b0, 1'b1);
        endAndWait("sparse_ce");
        ceMode = 0;
    endtask

    task automatic test_overflow();
        startFrame();
        for (int i = 1; i <= 6; i++) sendByte(8'(i), 1'b0, 1'b1);
        endAndWait("overflow");
    endtask

    task automatic test_end_same_cycle();
        startFrame();
        sendByte(8'h10, 1'b0, 1'b1);
        sendByte(8'hFF, 1'b1, 1'b1);
        endAndWait("end_same");
    endtask

    task automatic test_reset_midload();
        startFrame();
        sendByte(8'h01, 1'b0, 1'b1);
        sendByte(8'h02, 1'b0, 1'b1);
        // Third byte is accepted, then reset lands in its write cycle
        sendByte(8'h03, 1'b0, 1'b0);
        reset         = 1'b1;
        bus.dl_active = 1'b0;
        bus.dl_valid  = 1'b0;
        repeat (2) tick();
        checkIdleZero("midload_reset");
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (weCount != 2) begin
            errors++;
            $display("[TB] FAIL midload we_count got %0d want 2", weCount);
        end
        checkIdleZero("midload_after");
        startFrame();
        sendByte(8'hAA, 1'b0, 1'b1);
        endAndWait("after_reset_frame");
    endtask

    task automatic test_zero_length();
        startFrame();
        tick();
        endAndWait("zero_length");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sparse_ce();
        test_overflow();
        test_end_same_cycle();
        test_reset_midload();
        test_zero_length();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
